instr_fetch: RTL

//  Program counter and fetch sequencer. Drives InstAddress into the combinational

---
 rtl/instr_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
//==============================================================================
// Module      : instr_fetch
// Description : Program counter and fetch sequencer (IDLE/RUN/HALTED) feeding a
//               combinational ROM. Optional macro INSTR_FETCH_CYCLES_EN adds a
//               saturating RUN-cycle counter on CycleCount.
// Revision    : 1.0 - initial release
//==============================================================================
module instr_fetch #(
    parameter int PC_W    = 11,
    parameter int INSTR_W = 9,
    parameter int OFF_W   = 6
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    input  logic [PC_W-1:0]    StartAddr,
    input  logic               Stall,
    input  logic               BranchRel,
    input  logic [OFF_W-1:0]   Offset,
    input  logic               Jump,
    input  logic [PC_W-1:0]    Target,
    input  logic               HaltReq,
    input  logic [INSTR_W-1:0] InstIn,
    output logic [PC_W-1:0]    InstAddress,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstValid,
`ifdef INSTR_FETCH_CYCLES_EN
    output logic [15:0]        CycleCount,
`endif
    output logic               Done
);

    localparam logic [1:0]      c_IDLE   = 2'd0;
    localparam logic [1:0]      c_RUN    = 2'd1;
    localparam logic [1:0]      c_HALTED = 2'd2;
    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_offset_sext;

    assign w_offset_sext = {{(PC_W-OFF_W){Offset[OFF_W-1]}}, Offset};

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Start overrides every control input; in RUN the rest follow strict priority.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            c_IDLE, c_HALTED: begin
                if (Start) begin
                    w_state_nxt = c_RUN;
                    w_pc_nxt    = StartAddr;
                end
            end
            c_RUN: begin
                if (Start) begin
                    w_pc_nxt = StartAddr;
                end else if (HaltReq) begin
                    w_state_nxt = c_HALTED;
                end else if (Stall) begin
                    w_pc_nxt = r_pc;
                end else if (Jump) begin
                    w_pc_nxt = Target;
                end else if (BranchRel) begin
                    w_pc_nxt = r_pc + w_offset_sext;
                end else begin
                    w_pc_nxt = r_pc + c_PC_ONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_pc_nxt    = '0;
            end
        endcase
    end

    assign InstAddress = r_pc;
    assign InstValid   = (r_state == c_RUN) && !Stall;
    assign Instruction = InstValid ? InstIn : '0;
    assign Done        = (r_state == c_HALTED);

`ifdef INSTR_FETCH_CYCLES_EN
    logic [15:0] r_cycles;

    always_ff @(posedge CLK) begin
        if (Reset || Start) begin
            r_cycles <= '0;
        end else if ((r_state == c_RUN) && (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign CycleCount = r_cycles;
`endif

endmodule
`default_nettype wire
